// File: rtl/apb_slave_regs.sv
// APB completer with a fixed wait-state count and a small register file.
// The top register is a read-only count of successfully completed transfers.
module apb_slave_regs #(
    parameter int         SLAVE_IDX   = 0,
    parameter logic [7:0] BASE_ADDR   = 8'h10,
    parameter int         NUM_REGS    = 16,
    parameter int         WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        PRESET,
    input  logic [2:0]  PSEL,
    input  logic        PENABLE,
    input  logic [7:0]  PADDR,
    input  logic        PWRITE,
    input  logic [20:0] PWDATA,
    output logic        PREADY,
    output logic [20:0] PRDATA,
    output logic        PSLVERR
);

    localparam int            IW   = $clog2(NUM_REGS);
    localparam logic [IW-1:0] LAST = IW'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          hit_q, hit_d;
    logic          write_q, write_d;
    logic [20:0]   wdata_q, wdata_d;
    logic          pready_q, pready_d;
    logic          pslverr_q, pslverr_d;
    logic [20:0]   prdata_q, prdata_d;
    logic [20:0]   regs_q [NUM_REGS];

    logic       sel;
    logic       setup;
    logic       valid;
    logic [7:0] addr_off;
    logic       addr_hit;
    logic       err_cur;
    logic       err_nxt;
    logic       unused_ok;

    assign sel       = PSEL[SLAVE_IDX];
    assign setup     = sel && !PENABLE;
    assign valid     = sel && PENABLE;
    assign addr_off  = PADDR - BASE_ADDR;
    assign addr_hit  = (PADDR >= BASE_ADDR) && (addr_off < 8'(NUM_REGS));
    assign unused_ok = ^PSEL;

    // Error status of the transfer in flight (committing) and of the one about to respond.
    assign err_cur = !hit_q || (write_q && (idx_q == LAST));
    assign err_nxt = !hit_d || (write_d && (idx_d == LAST));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        hit_d   = hit_q;
        write_d = write_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (setup) begin
                    idx_d   = addr_off[IW-1:0];
                    hit_d   = addr_hit;
                    write_d = PWRITE;
                    wdata_d = PWDATA;
                    cnt_d   = 4'(WAIT_CYCLES);
                    // With no wait states the first access cycle is already the PREADY cycle.
                    state_d = (WAIT_CYCLES == 0) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (!valid) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q <= 4'd1) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        pready_d  = (state_d == DONE);
        pslverr_d = pready_d && err_nxt;
        prdata_d  = '0;
        if (pready_d && !err_nxt && !write_d) begin
            prdata_d = regs_q[idx_d];
        end
    end

    always_ff @(posedge clk or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            idx_q     <= '0;
            hit_q     <= 1'b0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            hit_q     <= hit_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            // Commit on the edge that ends the PREADY cycle.
            if (state_q == DONE && !err_cur) begin
                if (write_q) begin
                    regs_q[idx_q] <= wdata_q;
                end
                regs_q[LAST] <= regs_q[LAST] + 21'd1;
            end
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule

// File: tb/tb_apb_slave_regs.sv
// Bench for apb_slave_regs: two instances share one bus (select bit 0 with two
// wait states, select bit 1 with none), checked every cycle against a transfer-level model.
module tb_apb_slave_regs;

    logic        clk;
    logic        rst;
    logic [2:0]  psel;
    logic        penable;
    logic [7:0]  paddr;
    logic        pwrite;
    logic [20:0] pwdata;
    logic [1:0]  pready_v;
    logic [1:0]  pslverr_v;
    logic [20:0] prdata_v [2];

    apb_slave_regs #(.SLAVE_IDX(0), .BASE_ADDR(8'h10), .NUM_REGS(16), .WAIT_CYCLES(2)) u_dut0 (
        .clk(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_v[0]), .PRDATA(prdata_v[0]),
        .PSLVERR(pslverr_v[0]));

    apb_slave_regs #(.SLAVE_IDX(1), .BASE_ADDR(8'h10), .NUM_REGS(16), .WAIT_CYCLES(0)) u_dut1 (
        .clk(clk), .PRESET(rst), .PSEL(psel), .PENABLE(penable), .PADDR(paddr),
        .PWRITE(pwrite), .PWDATA(pwdata), .PREADY(pready_v[1]), .PRDATA(prdata_v[1]),
        .PSLVERR(pslverr_v[1]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model state: register contents per slave (index 15 is the transfer count).
    logic [20:0] mem [2][16];
    logic        exp_rdy [2];
    logic        exp_err [2];
    logic [20:0] exp_rd  [2];
    logic [20:0] last_rd  [2];
    logic        last_err [2];
    int          pcount   [2];

    task automatic chk(input string name, input logic [20:0] act, input logic [20:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic clear_exp();
        for (int s = 0; s < 2; s++) begin
            exp_rdy[s] = 1'b0;
            exp_err[s] = 1'b0;
            exp_rd[s]  = '0;
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < 2; s++)
            for (int r = 0; r < 16; r++)
                mem[s][r] = '0;
    endtask

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("pready%0d", s), 21'(pready_v[s]), 21'(exp_rdy[s]));
            chk($sformatf("pslverr%0d", s), 21'(pslverr_v[s]), 21'(exp_err[s]));
            chk($sformatf("prdata%0d", s), prdata_v[s], exp_rd[s]);
            if (pready_v[s] === 1'b1) begin
                last_rd[s]  = prdata_v[s];
                last_err[s] = pslverr_v[s];
                pcount[s]++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n, input bit noise);
        for (int i = 0; i < n; i++) begin
            // Select asserted with PENABLE high from idle is a protocol error the slaves must ignore.
            if (noise && ($urandom_range(0, 1) == 1)) begin
                psel    = 3'($urandom);
                penable = 1'b1;
            end else begin
                psel    = 3'b000;
                penable = 1'b0;
            end
            paddr  = 8'($urandom);
            pwdata = 21'($urandom);
            clear_exp();
            step();
        end
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    // s = select bit to drive (0, 1 or 2; bit 2 has no responder).
    task automatic xfer(input int s, input logic [7:0] a, input logic w, input logic [20:0] d,
                        input int abort_at, input bit drop_sel, input int reset_at);
        int          wc;
        bit          in_rng;
        int          idx;
        bit          err;
        logic [20:0] rd;
        wc     = (s == 1) ? 0 : 2;
        in_rng = (a >= 8'h10) && (a < 8'h20);
        idx    = int'(a) - 16;
        err    = !in_rng || (w && idx == 15);
        rd     = '0;
        if (s < 2 && !err && !w) rd = mem[s][idx];
        psel    = 3'(1 << s);
        penable = 1'b0;
        paddr   = a;
        pwrite  = w;
        pwdata  = d;
        clear_exp();
        step();
        for (int j = 0; j <= wc; j++) begin
            penable = 1'b1;
            paddr   = 8'($urandom);
            pwdata  = 21'($urandom);
            clear_exp();
            if (j == reset_at) begin
                rst = 1'b1;
                model_reset();
                psel    = 3'b000;
                penable = 1'b0;
                step();
                step();
                rst = 1'b0;
                return;
            end
            if (j == abort_at) begin
                if (drop_sel) psel = 3'b000;
                else          penable = 1'b0;
                step();
                psel    = 3'b000;
                penable = 1'b0;
                return;
            end
            if (j == wc && s < 2) begin
                exp_rdy[s] = 1'b1;
                exp_err[s] = err;
                exp_rd[s]  = rd;
            end
            step();
        end
        if (s < 2 && !err) begin
            if (w) mem[s][idx] = d;
            mem[s][15] = mem[s][15] + 21'd1;
        end
        clear_exp();
        psel    = 3'b000;
        penable = 1'b0;
    endtask

    initial begin
        int p0;
        int p1;
        rst     = 1'b1;
        psel    = 3'b000;
        penable = 1'b0;
        paddr   = '0;
        pwrite  = 1'b0;
        pwdata  = '0;
        for (int s = 0; s < 2; s++) begin
            pcount[s]   = 0;
            last_rd[s]  = '0;
            last_err[s] = 1'b0;
        end
        model_reset();
        clear_exp();
        repeat (3) step();
        rst = 1'b0;
        step();

        // Directed sequence on slave 0 (two wait states).
        xfer(0, 8'h12, 1'b1, 21'd10, -1, 1'b0, -1);
        chk("wr12_err", 21'(last_err[0]), 21'd0);
        idle(1, 1'b0);
        xfer(0, 8'h1F, 1'b0, '0, -1, 1'b0, -1);
        chk("cnt_before_inc", last_rd[0], 21'd1);
        xfer(0, 8'h12, 1'b0, '0, -1, 1'b0, -1);
        chk("rd12_lit", last_rd[0], 21'd10);
        chk("model_cnt", mem[0][15], 21'd3);
        xfer(0, 8'h40, 1'b1, 21'd5, -1, 1'b0, -1);
        chk("oor_err", 21'(last_err[0]), 21'd1);
        xfer(0, 8'h1F, 1'b1, 21'd7, -1, 1'b0, -1);
        chk("ro_err", 21'(last_err[0]), 21'd1);
        xfer(0, 8'h1F, 1'b0, '0, -1, 1'b0, -1);
        chk("cnt_after_err", last_rd[0], 21'd3);

        p0 = pcount[0];
        xfer(0, 8'h13, 1'b1, 21'd99, 1, 1'b0, -1);
        chk("abort_no_ready", 21'(pcount[0] - p0), 21'd0);
        xfer(0, 8'h13, 1'b0, '0, -1, 1'b0, -1);
        chk("abort_no_write", last_rd[0], 21'd0);

        xfer(0, 8'h14, 1'b1, 21'd55, -1, 1'b0, 1);
        xfer(0, 8'h1F, 1'b0, '0, -1, 1'b0, -1);
        chk("cnt_after_reset", last_rd[0], 21'd0);
        xfer(0, 8'h14, 1'b0, '0, -1, 1'b0, -1);
        chk("reg_after_reset", last_rd[0], 21'd0);

        // Select bit 1 only: slave 0 stays silent; slave 1 answers with no wait states.
        p0 = pcount[0];
        p1 = pcount[1];
        xfer(1, 8'h10, 1'b1, 21'h1ABCD, -1, 1'b0, -1);
        xfer(1, 8'h11, 1'b1, 21'h00777, -1, 1'b0, -1);
        chk("b2b_ready_count", 21'(pcount[1] - p1), 21'd2);
        chk("other_sel_silent", 21'(pcount[0] - p0), 21'd0);
        xfer(1, 8'h11, 1'b0, '0, -1, 1'b0, -1);
        chk("b2b_rd11", last_rd[1], 21'h00777);
        xfer(2, 8'h12, 1'b1, 21'd1, -1, 1'b0, -1);
        chk("unclaimed_sel", 21'(pcount[0] + pcount[1] - p0 - p1), 21'd3);

        // Randomised traffic across both slaves and the unclaimed select bit.
        for (int n = 0; n < 400; n++) begin
            int          s;
            logic [7:0]  a;
            logic        w;
            int          ab;
            int          rs;
            s  = $urandom_range(0, 2);
            a  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'(8'h0E + $urandom_range(0, 19));
            w  = 1'($urandom);
            ab = -1;
            rs = -1;
            if (s != 1 && $urandom_range(0, 7) == 0) ab = $urandom_range(0, 1);
            if ($urandom_range(0, 59) == 0) rs = $urandom_range(0, (s == 1) ? 0 : 2);
            xfer(s, a, w, 21'($urandom), ab, 1'($urandom), rs);
            idle($urandom_range(0, 2), 1'b1);
        end

        idle(2, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
